// File: rtl/ws2812_stream_tx.sv
// WS2812-class single-wire LED driver: valid/ready pixel stream in, MSB-first pulse-width coded bits out.
// A one-entry holding register prefetches the next pixel so consecutive pixels are sent back to back.
module ws2812_stream_tx #(
  parameter int NUM_PIXELS     = 8,
  parameter int BITS_PER_PIXEL = 24,
  parameter int T0H            = 6,
  parameter int T0L            = 14,
  parameter int T1H            = 13,
  parameter int T1L            = 7,
  parameter int RES            = 880
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun
);

  localparam int TM_A = (T0H > T0L) ? T0H : T0L;
  localparam int TM_B = (T1H > T1L) ? T1H : T1L;
  localparam int TM_C = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int TMAX = (TM_C > RES) ? TM_C : RES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BITS_PER_PIXEL + 1);
  localparam int PW   = $clog2(NUM_PIXELS + 1);

  typedef enum logic [2:0] {IDLE, WAIT0, HIGH, LOW, LATCH} state_t;

  state_t                    state, state_nx;
  logic                      hold_full;
  logic [BITS_PER_PIXEL-1:0] hold_data, shreg;
  logic [TW-1:0]             timer, dur_m1;
  logic [BW-1:0]             bit_cnt;
  logic [PW-1:0]             acc_cnt, pix_cnt;
  logic                      cur_bit, phase_last, last_bit, last_pix, accept;
  logic                      frame_start, load, shift, next_pix, underrun_nx, done_nx;

  assign cur_bit    = shreg[BITS_PER_PIXEL-1];
  assign last_bit   = (bit_cnt == BW'(BITS_PER_PIXEL - 1));
  assign last_pix   = (pix_cnt == PW'(NUM_PIXELS - 1));
  assign pix_ready  = (state != IDLE) && (state != LATCH) && !hold_full && (acc_cnt < PW'(NUM_PIXELS));
  assign accept     = pix_valid && pix_ready;
  assign busy       = (state != IDLE);
  assign phase_last = (timer == dur_m1);

  // Length of the current phase minus one; LOW uses the same bit as its HIGH since the shift comes after.
  always_comb begin
    dur_m1 = '0;
    case (state)
      HIGH:    dur_m1 = cur_bit ? TW'(T1H - 1) : TW'(T0H - 1);
      LOW:     dur_m1 = cur_bit ? TW'(T1L - 1) : TW'(T0L - 1);
      LATCH:   dur_m1 = TW'(RES - 1);
      default: dur_m1 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    next_pix    = 1'b0;
    underrun_nx = 1'b0;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_nx    = WAIT0;
        end
      end
      WAIT0: begin
        if (hold_full) begin
          load     = 1'b1;
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (phase_last) state_nx = LOW;
      end
      LOW: begin
        if (phase_last) begin
          if (!last_bit) begin
            shift    = 1'b1;
            state_nx = HIGH;
          end else if (last_pix) begin
            state_nx = LATCH;
          end else if (hold_full) begin
            load     = 1'b1;
            next_pix = 1'b1;
            state_nx = HIGH;
          end else begin
            underrun_nx = 1'b1;
            state_nx    = LATCH;
          end
        end
      end
      LATCH: begin
        if (phase_last) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // dout follows the state by one register so the pin is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full  <= 1'b0;
      acc_cnt    <= '0;
      pix_cnt    <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      dout       <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout       <= (state == HIGH);
      underrun   <= underrun_nx;
      frame_done <= done_nx;
      if ((state_nx != state) || (state == IDLE) || (state == WAIT0)) timer <= '0;
      else                                                            timer <= timer + TW'(1);
      if (state == LATCH) hold_full <= 1'b0;
      else if (accept)    hold_full <= 1'b1;
      else if (load)      hold_full <= 1'b0;
      if (frame_start) acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + PW'(1);
      if (frame_start)   pix_cnt <= '0;
      else if (next_pix) pix_cnt <= pix_cnt + PW'(1);
      if (load)       bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) hold_data <= pix_data;
    if (load)       shreg <= hold_data;
    else if (shift) shreg <= shreg << 1;
  end

endmodule
